// File: rtl/mm_burst_bridge_pkg.sv
// Shared constants, FSM encodings and the command record for the cache-line to burst-memory bridge.
package mm_burst_bridge_pkg;
    localparam int WORD_BITS = 32;
    localparam int BEATS     = 8;
    localparam int LINE_BITS = WORD_BITS * BEATS;
    localparam int ADDR_BITS = 32;
    localparam int OFF_BITS  = 5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_BURST = 3'd1;
    localparam logic [2:0] ST_RD_CMD   = 3'd2;
    localparam logic [2:0] ST_RD_DATA  = 3'd3;
    localparam logic [2:0] ST_RD_DONE  = 3'd4;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef struct packed {
        logic                            kind;
        logic [ADDR_BITS-OFF_BITS-1:0]   line;
        logic [LINE_BITS-1:0]            wd;
    } cmd_t;
endpackage

// File: rtl/mm_cmd_slot.sv
// One-entry holding register for a queued cache command; load and pop are never asserted together.
module mm_cmd_slot
    import mm_burst_bridge_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic pop_i,
    input  cmd_t cmd_i,
    output logic full_o,
    output cmd_t cmd_o
);
    logic full_q, full_d;
    cmd_t cmd_q;

    always_comb begin
        full_d = full_q;
        if (load_i)
            full_d = 1'b1;
        else if (pop_i)
            full_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            cmd_q  <= '0;
        end else begin
            full_q <= full_d;
            if (load_i)
                cmd_q <= cmd_i;
        end
    end

    assign full_o = full_q;
    assign cmd_o  = cmd_q;
endmodule

// File: rtl/mm_burst_bridge.sv
// Converts 256b cache line evictions/fills into 8-beat Avalon-style write/read bursts,
// with one queued command so an eviction and a fill can be issued back to back.
module mm_burst_bridge
    import mm_burst_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] cc_a,
    input  logic [LINE_BITS-1:0] cc_wd,
    input  logic                 cc_write,
    input  logic                 cc_read,
    output logic                 cc_busy,
    output logic [LINE_BITS-1:0] cc_rd,
    output logic                 cc_readdata_valid,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_BITS-1:0] mem_writedata,
    output logic [3:0]           mem_burstcount,
    input  logic                 mem_waitrequest,
    input  logic [WORD_BITS-1:0] mem_readdata,
    input  logic                 mem_readdatavalid,
    output logic                 err_stray,
    output logic [2:0]           dbg_state
);
    logic [2:0] state_q, state_d;
    logic [2:0] beat_q, beat_d;
    cmd_t       act_q, act_d;
    logic       err_q, err_d;
    logic [LINE_BITS-WORD_BITS-1:0] buf_q;
    logic [LINE_BITS-1:0]           rd_q;

    cmd_t wr_cmd, rd_cmd, slot_din, slot_cmd;
    logic slot_load, slot_pop, slot_full, burst_done;
    logic [7:0] woff;
    logic cc_a_unused;

    assign wr_cmd      = {CMD_WRITE, cc_a[ADDR_BITS-1:OFF_BITS], cc_wd};
    assign rd_cmd      = {CMD_READ, cc_a[ADDR_BITS-1:OFF_BITS], {LINE_BITS{1'b0}}};
    assign woff        = {beat_q, 5'b0};
    assign cc_a_unused = ^cc_a[OFF_BITS-1:0];

    mm_cmd_slot u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (slot_load),
        .pop_i   (slot_pop),
        .cmd_i   (slot_din),
        .full_o  (slot_full),
        .cmd_o   (slot_cmd)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        act_d      = act_q;
        err_d      = err_q;
        slot_load  = 1'b0;
        slot_pop   = 1'b0;
        slot_din   = wr_cmd;
        burst_done = 1'b0;

        case (state_q)
            ST_WR_BURST: if (!mem_waitrequest) begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7)
                    burst_done = 1'b1;
            end
            ST_RD_CMD: if (!mem_waitrequest)
                state_d = ST_RD_DATA;
            ST_RD_DATA: if (mem_readdatavalid) begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7)
                    state_d = ST_RD_DONE;
            end
            ST_RD_DONE: burst_done = 1'b1;
            default: ;
        endcase

        if (mem_readdatavalid && state_q != ST_RD_DATA)
            err_d = 1'b1;

        // A free bridge takes a command straight into the active register; a
        // simultaneous write+read runs the write first and parks the read.
        if (state_q == ST_IDLE && !slot_full) begin
            if (cc_write) begin
                act_d   = wr_cmd;
                state_d = ST_WR_BURST;
                if (cc_read) begin
                    slot_load = 1'b1;
                    slot_din  = rd_cmd;
                end
            end else if (cc_read) begin
                act_d   = rd_cmd;
                state_d = ST_RD_CMD;
            end
        end else if (cc_write || cc_read) begin
            if (slot_full || (cc_write && cc_read))
                err_d = 1'b1;
            if (!slot_full) begin
                slot_load = 1'b1;
                slot_din  = cc_write ? wr_cmd : rd_cmd;
            end
        end

        if ((state_q == ST_IDLE || burst_done) && slot_full) begin
            slot_pop = 1'b1;
            act_d    = slot_cmd;
            state_d  = (slot_cmd.kind == CMD_WRITE) ? ST_WR_BURST : ST_RD_CMD;
        end else if (burst_done) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            beat_q  <= 3'd0;
            act_q   <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            act_q   <= act_d;
            err_q   <= err_d;
            // cc_rd only changes when the last beat lands, so the previous line stays visible.
            if (state_q == ST_RD_DATA && mem_readdatavalid) begin
                if (beat_q == 3'd7)
                    rd_q <= {mem_readdata, buf_q};
                else
                    buf_q[woff +: WORD_BITS] <= mem_readdata;
            end
        end
    end

    assign mem_write         = (state_q == ST_WR_BURST);
    assign mem_read          = (state_q == ST_RD_CMD);
    assign cc_readdata_valid = (state_q == ST_RD_DONE);
    assign mem_writedata     = act_q.wd[woff +: WORD_BITS];
    assign mem_address       = {act_q.line, {OFF_BITS{1'b0}}};
    assign mem_burstcount    = (mem_read || mem_write) ? 4'(BEATS) : 4'd0;
    assign cc_busy           = slot_full;
    assign cc_rd             = rd_q;
    assign err_stray         = err_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_mm_burst_bridge.sv
// Directed scoreboard bench for mm_burst_bridge: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_mm_burst_bridge;
  logic         clk;
  logic         reset_n;
  logic [31:0]  cc_a;
  logic [255:0] cc_wd;
  logic         cc_write, cc_read;
  logic         cc_busy;
  logic [255:0] cc_rd;
  logic         cc_readdata_valid;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [31:0]  mem_writedata;
  logic [3:0]   mem_burstcount;
  logic         mem_waitrequest;
  logic [31:0]  mem_readdata;
  logic         mem_readdatavalid;
  logic         err_stray;
  logic [2:0]   dbg_state;

  logic         rdv_model, rdv_stray;
  logic [31:0]  rdd_model, rdd_stray;
  assign mem_readdatavalid = rdv_model | rdv_stray;
  assign mem_readdata      = rdv_stray ? rdd_stray : rdd_model;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [63:0]  exp_wr_q[$];
  logic [31:0]  exp_rdcmd_q[$];
  logic [255:0] exp_line_q[$];
  int           exp_vcyc_q[$];
  logic [31:0]  rd_base_q[$];

  mm_burst_bridge dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cc_a              (cc_a),
    .cc_wd             (cc_wd),
    .cc_write          (cc_write),
    .cc_read           (cc_read),
    .cc_busy           (cc_busy),
    .cc_rd             (cc_rd),
    .cc_readdata_valid (cc_readdata_valid),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_burstcount    (mem_burstcount),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .err_stray         (err_stray),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  // driver tasks
  task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [255:0] wd);
    cc_write = w;
    cc_read  = r;
    cc_a     = a;
    cc_wd    = wd;
    @(posedge clk); #1;
    cc_write = 1'b0;
    cc_read  = 1'b0;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] base);
    for (int i = 0; i < 8; i++) exp_wr_q.push_back({a & 32'hFFFF_FFE0, base + 32'(i)});
  endtask

  task automatic push_read(input logic [31:0] a, input logic [31:0] base, input int vcyc);
    exp_rdcmd_q.push_back(a & 32'hFFFF_FFE0);
    rd_base_q.push_back(base);
    exp_line_q.push_back(mk_line(base));
    exp_vcyc_q.push_back(vcyc);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_wr_q.size() != 0 || exp_rdcmd_q.size() != 0 || exp_line_q.size() != 0 ||
            dbg_state != 3'd0 || cc_busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout: state=%0d after %0d cycles, want idle", dbg_state, n);
    end
  endtask

  // memory responder: zero-wait command, beats start two cycles after acceptance
  initial begin
    rdv_model = 1'b0;
    rdd_model = '0;
    forever begin
      @(negedge clk);
      if (reset_n && mem_read && !mem_waitrequest) begin
        logic [31:0] base;
        base = (rd_base_q.size() != 0) ? rd_base_q.pop_front() : 32'h0;
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
          if (!reset_n) break;
          rdv_model = 1'b1;
          rdd_model = base + 32'(i);
          @(posedge clk); #1;
        end
        rdv_model = 1'b0;
        rdd_model = '0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_read || mem_write) begin
        check("rw_exclusive", {255'b0, mem_read & mem_write}, 256'd0);
        check("burstcount", {252'b0, mem_burstcount}, 256'd8);
      end
      if (mem_write && !mem_waitrequest) begin
        if (exp_wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got beat %0h at %0h want none", mem_writedata, mem_address);
        end else begin
          check("wr_beat", {192'b0, mem_address, mem_writedata}, {192'b0, exp_wr_q.pop_front()});
        end
      end
      if (mem_read && !mem_waitrequest) begin
        if (exp_rdcmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got read cmd at %0h want none", mem_address);
        end else begin
          check("rd_cmd_addr", {224'b0, mem_address}, {224'b0, exp_rdcmd_q.pop_front()});
        end
      end
      if (cc_readdata_valid) begin
        if (exp_line_q.size() == 0) begin
          total++; bad++;
          $display("FAIL valid_unexpected: got line %0h want none", cc_rd);
        end else begin
          check("rd_line", cc_rd, exp_line_q.pop_front());
          check("rd_latency", 256'(cyc), 256'(exp_vcyc_q.pop_front()));
        end
      end
    end
  end

  // stimulus
  initial begin
    int c;
    reset_n = 1'b0;
    cc_a = '0; cc_wd = '0; cc_write = 1'b0; cc_read = 1'b0;
    mem_waitrequest = 1'b0;
    rdv_stray = 1'b0; rdd_stray = '0;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_busy", {255'b0, cc_busy}, 256'd0);
    check("rst_rd", cc_rd, 256'd0);
    check("rst_ctl", {250'b0, cc_readdata_valid, mem_read, mem_write, err_stray, mem_burstcount == 4'd0, 1'b0}, 256'd2);
    check("rst_addr", {224'b0, mem_address}, 256'd0);
    check("rst_state", {253'b0, dbg_state}, 256'd0);

    // fill, zero wait
    c = cyc;
    push_read(32'h0001_2344, 32'h100, c + 11);
    issue(1'b0, 1'b1, 32'h0001_2344, '0);
    wait_drain(40);

    // eviction with stalls on beats 0 and 5
    push_write(32'h0000_8000, 32'hA0);
    issue(1'b1, 1'b0, 32'h0000_8000, mk_line(32'hA0));
    for (int k = 1; k <= 14; k++) begin
      mem_waitrequest = (k == 1 || k == 2 || k == 8 || k == 9);
      @(posedge clk); #1;
    end
    mem_waitrequest = 1'b0;
    wait_drain(40);

    // same-cycle write + read
    c = cyc;
    push_write(32'h0000_A000, 32'hB0);
    push_read(32'h0000_A000, 32'h200, c + 19);
    issue(1'b1, 1'b1, 32'h0000_A000, mk_line(32'hB0));
    check("t3_busy_start", {255'b0, cc_busy}, 256'd1);
    repeat (7) begin @(posedge clk); #1; end
    check("t3_busy_wr_end", {255'b0, cc_busy}, 256'd1);
    @(posedge clk); #1;
    check("t3_busy_popped", {255'b0, cc_busy}, 256'd0);
    wait_drain(40);

    // evict then fill back to back, third command dropped
    c = cyc;
    push_write(32'h0000_1000, 32'hC0);
    issue(1'b1, 1'b0, 32'h0000_1000, mk_line(32'hC0));
    push_read(32'h0000_2000, 32'h300, c + 19);
    issue(1'b0, 1'b1, 32'h0000_2000, '0);
    check("t4_busy", {255'b0, cc_busy}, 256'd1);
    check("t4_err_before", {255'b0, err_stray}, 256'd0);
    issue(1'b1, 1'b0, 32'h0000_3000, mk_line(32'hE0));
    check("t4_err_drop", {255'b0, err_stray}, 256'd1);
    wait_drain(60);

    // reset during read beat 4
    exp_rdcmd_q.push_back(32'h0000_4000);
    rd_base_q.push_back(32'h400);
    issue(1'b0, 1'b1, 32'h0000_4000, '0);
    repeat (6) @(posedge clk);
    #3;
    check("t5_in_rddata", {253'b0, dbg_state}, 256'd3);
    reset_n = 1'b0;
    #1;
    check("t5_rst_ctl", {216'b0, cc_busy, cc_readdata_valid, mem_read, mem_write, mem_burstcount,
                         err_stray, dbg_state, mem_writedata}, 256'd0);
    check("t5_rst_addr", {224'b0, mem_address}, 256'd0);
    check("t5_rst_rd", cc_rd, 256'd0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("t5_err_cleared", {255'b0, err_stray}, 256'd0);
    c = cyc;
    push_read(32'h0000_5004, 32'h500, c + 11);
    issue(1'b0, 1'b1, 32'h0000_5004, '0);
    wait_drain(40);

    // stray readdatavalid while idle
    rdv_stray = 1'b1;
    rdd_stray = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rdv_stray = 1'b0;
    check("t6_err", {255'b0, err_stray}, 256'd1);
    check("t6_rd_kept", cc_rd, mk_line(32'h500));
    check("t6_state", {253'b0, dbg_state}, 256'd0);
    @(posedge clk); #1;
    check("t6_state_hold", {253'b0, dbg_state}, 256'd0);

    check("queues_empty", 256'(exp_wr_q.size() + exp_rdcmd_q.size() + exp_line_q.size()), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
